// File: rtl/stepper_pkg.sv
// Shared definitions for stepper move sequencing.
// Contents: sequencer state enum, direction encodings, default widths and
// timings (also meant for a future multi-axis top), and a helper that sizes
// the shared down-counter.
package stepper_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StDirSetup,
      StWaitTick,
      StPulse,
      StDone
   } state_e;

   localparam logic DIR_POS = 1'b1;
   localparam logic DIR_NEG = 1'b0;

   localparam int unsigned DEF_STEP_W           = 16;
   localparam int unsigned DEF_POS_W            = 32;
   localparam int unsigned DEF_PULSE_CYCLES     = 500;
   localparam int unsigned DEF_DIR_SETUP_CYCLES = 200;

   // Width that holds max(a, b) - 1. The counter is loaded with (cycles - 1).
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/stepper_move_controller_down_counter.sv
// Loadable down-counter with a zero flag. It times both the step pulse
// width and the direction setup delay, which never overlap.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   load_i        load load_val_i (takes priority over en_i)
//   load_val_i    value to load
//   en_i          decrement by one; holds at zero
//   zero_o        count is zero
module stepper_move_controller_down_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/stepper_move_controller.sv
// Single-axis move sequencer for one stepper driver.
// Takes signed relative moves over valid/ready, sets direction (with an
// optional setup delay on a direction change), and issues |steps| pulses,
// each launched by a step_tick strobe. Tracks absolute position.
// Ports:
//   clk_100mhz_i, rst_i      clock, async active-high reset
//   step_tick_i              one-cycle step-rate strobe
//   cmd_valid_i/cmd_ready_o  command handshake; ready only in idle
//   cmd_steps_i              signed step count, sign selects direction
//   abort_i                  level; ends the move at the next safe point
//   motor_step_o/motor_dir_o driver pins (dir 1 = positive)
//   busy_o, done_o, aborted_o  move status (done/aborted are 1-cycle pulses)
//   position_o               signed absolute position (wraps)
//   steps_remaining_o        steps still to issue
module stepper_move_controller
   import stepper_pkg::*;
#(
   parameter int unsigned STEP_W           = DEF_STEP_W,
   parameter int unsigned POS_W            = DEF_POS_W,
   parameter int unsigned PULSE_CYCLES     = DEF_PULSE_CYCLES,
   parameter int unsigned DIR_SETUP_CYCLES = DEF_DIR_SETUP_CYCLES
) (
   input  logic                     clk_100mhz_i,
   input  logic                     rst_i,
   input  logic                     step_tick_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic signed [STEP_W-1:0] cmd_steps_i,
   input  logic                     abort_i,
   output logic                     motor_step_o,
   output logic                     motor_dir_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     aborted_o,
   output logic signed [POS_W-1:0]  position_o,
   output logic [STEP_W-1:0]        steps_remaining_o
);

   localparam int unsigned CntW        = cnt_width(PULSE_CYCLES, DIR_SETUP_CYCLES);
   localparam bit          HasDirSetup = (DIR_SETUP_CYCLES != 0);
   localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYCLES - 1);
   localparam logic [CntW-1:0] DirLoad   = CntW'(HasDirSetup ? DIR_SETUP_CYCLES - 1 : 0);

   state_e            state_q;
   logic              motor_step_q;
   logic              motor_dir_q;
   logic              busy_q;
   logic              done_q;
   logic              aborted_q;
   logic              abort_pend_q;
   logic [POS_W-1:0]  position_q;
   logic [STEP_W-1:0] steps_rem_q;

   logic              cmd_accept;
   logic              new_dir;
   logic [STEP_W:0]   cmd_ext;
   logic [STEP_W:0]   cmd_mag;
   logic              cmd_zero;
   logic              need_setup;
   logic [POS_W-1:0]  pos_delta;
   logic              last_step;

   logic              cnt_load;
   logic [CntW-1:0]   cnt_load_val;
   logic              cnt_en;
   logic              cnt_zero;

   // Magnitude in STEP_W+1 bits so the most-negative count is representable.
   assign cmd_ext    = {cmd_steps_i[STEP_W-1], cmd_steps_i};
   assign cmd_mag    = cmd_steps_i[STEP_W-1] ? (~cmd_ext + (STEP_W+1)'(1)) : cmd_ext;
   assign cmd_zero   = (cmd_mag == '0);
   assign new_dir    = ~cmd_steps_i[STEP_W-1];
   assign cmd_accept = cmd_valid_i && (state_q == StIdle);
   assign need_setup = HasDirSetup && !cmd_zero && (new_dir != motor_dir_q);
   assign pos_delta  = (motor_dir_q == DIR_POS) ? POS_W'(1) : '1;
   assign last_step  = (steps_rem_q == STEP_W'(1));

   // Timer control: loaded on entry to DIR_SETUP/PULSE, counted while there.
   always_comb begin
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_en       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_accept && need_setup) begin
               cnt_load     = 1'b1;
               cnt_load_val = DirLoad;
            end
         end
         StDirSetup: cnt_en = 1'b1;
         StWaitTick: begin
            if (step_tick_i && !abort_i) begin
               cnt_load     = 1'b1;
               cnt_load_val = PulseLoad;
            end
         end
         StPulse: cnt_en = 1'b1;
         default: ;
      endcase
   end

   stepper_move_controller_down_counter #(
      .W (CntW)
   ) u_timer (
      .clk_i      (clk_100mhz_i),
      .rst_i      (rst_i),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .en_i       (cnt_en),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge clk_100mhz_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         motor_step_q <= 1'b0;
         motor_dir_q  <= DIR_POS;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         abort_pend_q <= 1'b0;
         position_q   <= '0;
         steps_rem_q  <= '0;
      end else begin
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               abort_pend_q <= 1'b0;
               if (cmd_accept) begin
                  steps_rem_q <= cmd_mag[STEP_W-1:0];
                  if (cmd_zero) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     motor_dir_q <= new_dir;
                     busy_q      <= 1'b1;
                     state_q     <= need_setup ? StDirSetup : StWaitTick;
                  end
               end
            end
            StDirSetup: begin
               if (abort_i) begin
                  state_q   <= StDone;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  aborted_q <= 1'b1;
               end else if (cnt_zero) begin
                  state_q <= StWaitTick;
               end
            end
            StWaitTick: begin
               // Abort beats a coincident tick: no pulse is launched.
               if (abort_i) begin
                  state_q   <= StDone;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  aborted_q <= 1'b1;
               end else if (step_tick_i) begin
                  motor_step_q <= 1'b1;
                  state_q      <= StPulse;
               end
            end
            StPulse: begin
               // Abort during a pulse is remembered; the pulse always runs full width.
               if (abort_i) begin
                  abort_pend_q <= 1'b1;
               end
               if (cnt_zero) begin
                  motor_step_q <= 1'b0;
                  position_q   <= position_q + pos_delta;
                  steps_rem_q  <= steps_rem_q - STEP_W'(1);
                  if (last_step) begin
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else if (abort_pend_q || abort_i) begin
                     state_q   <= StDone;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     aborted_q <= 1'b1;
                  end else begin
                     state_q <= StWaitTick;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready_o       = (state_q == StIdle);
   assign motor_step_o      = motor_step_q;
   assign motor_dir_o       = motor_dir_q;
   assign busy_o            = busy_q;
   assign done_o            = done_q;
   assign aborted_o         = aborted_q;
   assign position_o        = position_q;
   assign steps_remaining_o = steps_rem_q;

endmodule

// File: tb/tb_stepper_move_controller.sv
// Directed bench for stepper_move_controller: a table of moves with
// hand-computed outcomes plus sequences for abort/tick collision,
// back-to-back commands and reset during a pulse. A negedge monitor checks
// pulse width, tick-to-pulse latency, direction setup gap and done/busy.
module tb_stepper_move_controller;

   localparam int unsigned STEP_W      = 16;
   localparam int unsigned POS_W       = 32;
   localparam int unsigned PULSE       = 4;
   localparam int unsigned DSETUP      = 3;
   localparam int          TICK_PERIOD = 20;

   logic                     clk;
   logic                     rst;
   logic                     step_tick;
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic signed [STEP_W-1:0] cmd_steps;
   logic                     abort;
   logic                     motor_step;
   logic                     motor_dir;
   logic                     busy;
   logic                     done;
   logic                     aborted;
   logic signed [POS_W-1:0]  position;
   logic [STEP_W-1:0]        steps_remaining;

   stepper_move_controller #(
      .STEP_W           (STEP_W),
      .POS_W            (POS_W),
      .PULSE_CYCLES     (PULSE),
      .DIR_SETUP_CYCLES (DSETUP)
   ) dut (
      .clk_100mhz_i      (clk),
      .rst_i             (rst),
      .step_tick_i       (step_tick),
      .cmd_valid_i       (cmd_valid),
      .cmd_ready_o       (cmd_ready),
      .cmd_steps_i       (cmd_steps),
      .abort_i           (abort),
      .motor_step_o      (motor_step),
      .motor_dir_o       (motor_dir),
      .busy_o            (busy),
      .done_o            (done),
      .aborted_o         (aborted),
      .position_o        (position),
      .steps_remaining_o (steps_remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Main-thread drive point: 2 time units after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Free-running tick: one cycle high every TICK_PERIOD clocks.
   int tick_phase = 0;
   initial begin
      step_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tick_phase = (tick_phase + 1) % TICK_PERIOD;
         step_tick  = (tick_phase == 0);
      end
   end

   // Pulse/done monitor.
   int   pulse_cnt = 0;
   int   done_cnt  = 0;
   int   width     = 0;
   int   dir_age   = 1000;
   bit   mon_en    = 1'b0;
   logic prev_step = 1'b0;
   logic prev_tick = 1'b0;
   logic prev_dir  = 1'b1;
   initial begin
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            width   = 0;
            dir_age = 1000;
         end else begin
            if (motor_dir !== prev_dir) dir_age = 0;
            else if (dir_age < 1000) dir_age++;
            if (motor_step && !prev_step) begin
               pulse_cnt++;
               check("rise_after_tick", prev_tick, 1);
               check("dir_setup_gap", dir_age >= int'(DSETUP + 1), 1);
            end
            if (motor_step) begin
               width++;
            end else if (prev_step) begin
               check("pulse_width", width, PULSE);
               width = 0;
            end
            if (done) begin
               done_cnt++;
               check("done_not_busy", busy, 0);
            end
            if (aborted) check("aborted_with_done", done, 1);
         end
         prev_step = motor_step;
         prev_tick = step_tick;
         prev_dir  = motor_dir;
      end
   end

   typedef struct {
      int steps;     // command
      int abort_at;  // assert abort for one cycle during this pulse (0 = never)
      int early;     // pulses seen 8 cycles after acceptance
      int pulses;
      int pos;
      bit dir;
      int rem;
      bit ab;
   } move_t;

   move_t moves[5];

   task automatic run_move(input int idx, input move_t v);
      int               p0, d0, done_i;
      bit               got_done, got_ab, ab_sent;
      logic [POS_W-1:0] pos_s;
      logic [STEP_W-1:0] rem_s;
      logic             dir_s;
      p0 = pulse_cnt; d0 = done_cnt;
      got_done = 1'b0; got_ab = 1'b0; ab_sent = 1'b0; done_i = -1;
      pos_s = '0; rem_s = '0; dir_s = 1'b0;
      // Accept one cycle before a tick so a direction-setup window swallows it.
      for (int i = 0; i < TICK_PERIOD + 5 && tick_phase != TICK_PERIOD - 1; i++) cyc();
      check($sformatf("row%0d_ready", idx), cmd_ready, 1);
      cmd_steps = v.steps[STEP_W-1:0];
      cmd_valid = 1'b1;
      cyc();
      cmd_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (i > 0) cyc();
         if (abort) abort = 1'b0;
         if (i == 8) check($sformatf("row%0d_early_pulses", idx), pulse_cnt - p0, v.early);
         if (v.abort_at > 0 && !ab_sent && (pulse_cnt - p0 == v.abort_at) && motor_step) begin
            abort   = 1'b1;
            ab_sent = 1'b1;
         end
         if (done) begin
            got_done = 1'b1;
            got_ab   = aborted;
            done_i   = i;
            pos_s    = position;
            rem_s    = steps_remaining;
            dir_s    = motor_dir;
            break;
         end
      end
      abort = 1'b0;
      cyc();
      cyc();
      check($sformatf("row%0d_done_seen", idx), got_done, 1);
      check($sformatf("row%0d_pulses", idx), pulse_cnt - p0, v.pulses);
      check($sformatf("row%0d_position", idx), pos_s, v.pos);
      check($sformatf("row%0d_dir", idx), dir_s, v.dir);
      check($sformatf("row%0d_remaining", idx), rem_s, v.rem);
      check($sformatf("row%0d_aborted", idx), got_ab, v.ab);
      check($sformatf("row%0d_done_once", idx), done_cnt - d0, 1);
      if (v.steps == 0) check($sformatf("row%0d_zero_latency", idx), done_i, 0);
   endtask

   initial begin
      int p0, d0, accepts, first_done_c, second_acc_c;
      rst = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; abort = 1'b0;

      moves[0] = '{ 3, 0, 1, 3, 3, 1'b1, 0, 1'b0};
      moves[1] = '{-2, 0, 0, 2, 1, 1'b0, 0, 1'b0};
      moves[2] = '{ 0, 0, 0, 0, 1, 1'b0, 0, 1'b0};
      moves[3] = '{10, 2, 0, 2, 3, 1'b1, 8, 1'b1};
      moves[4] = '{-1, 0, 0, 1, 2, 1'b0, 0, 1'b0};

      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      mon_en = 1'b1;

      // Reset state.
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_motor_step", motor_step, 0);
      check("rst_motor_dir", motor_dir, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_aborted", aborted, 0);
      check("rst_position", position, 0);
      check("rst_remaining", steps_remaining, 0);
      repeat (200) cyc();
      check("idle_no_pulses", pulse_cnt, 0);
      check("idle_no_done", done_cnt, 0);

      foreach (moves[i]) run_move(i, moves[i]);

      // Abort coincident with a tick in WAIT_TICK: abort wins, no pulse.
      p0 = pulse_cnt;
      cmd_steps = 16'sd5;
      cmd_valid = 1'b1;
      cyc();
      cmd_valid = 1'b0;
      for (int i = 0; i < 100 && !((pulse_cnt - p0 == 1) && !motor_step); i++) cyc();
      for (int i = 0; i < TICK_PERIOD + 5 && tick_phase != 0; i++) cyc();
      check("coinc_tick_high", step_tick, 1);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check("coinc_done", done, 1);
      check("coinc_aborted", aborted, 1);
      check("coinc_position", position, 3);
      check("coinc_remaining", steps_remaining, 4);
      repeat (30) cyc();
      check("coinc_pulses", pulse_cnt - p0, 1);

      // Back-to-back +1, +1 with cmd_valid held high.
      d0 = done_cnt;
      accepts = 0; first_done_c = -1; second_acc_c = -1;
      cmd_steps = 16'sd1;
      cmd_valid = 1'b1;
      for (int c = 0; c < 200 && accepts < 2; c++) begin
         if (done) begin
            check("b2b_no_ready_in_done", cmd_ready, 0);
            if (first_done_c < 0) first_done_c = c;
         end
         if (cmd_ready) begin
            accepts++;
            if (accepts == 2) second_acc_c = c;
         end
         cyc();
      end
      cmd_valid = 1'b0;
      for (int i = 0; i < 100 && !done; i++) cyc();
      check("b2b_second_done", done, 1);
      cyc();
      cyc();
      check("b2b_accepts", accepts, 2);
      check("b2b_accept_after_done", second_acc_c, first_done_c + 1);
      check("b2b_done_count", done_cnt - d0, 2);
      check("b2b_position", position, 5);

      // Reset in the middle of a pulse.
      cmd_steps = 16'sd2;
      cmd_valid = 1'b1;
      cyc();
      cmd_valid = 1'b0;
      for (int i = 0; i < 60 && !motor_step; i++) cyc();
      check("midrst_pulse_started", motor_step, 1);
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_motor_step", motor_step, 0);
      check("midrst_position", position, 0);
      check("midrst_busy", busy, 0);
      check("midrst_dir", motor_dir, 1);
      check("midrst_remaining", steps_remaining, 0);
      check("midrst_ready", cmd_ready, 1);
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      check("postrst_ready", cmd_ready, 1);
      check("postrst_position", position, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
